// File: rtl/prbs_ber_checker.sv
// Receive-side PRBS checker: decimates oversampled filter output at a chosen phase,
// self-synchronises a local PRBS7/9/15 LFSR and counts checked bits and errors while locked.
module prbs_ber_checker #(
  parameter int NB         = 8,
  parameter int OS         = 4,
  parameter int PRBS_ORDER = 9,
  parameter int LOCK_LEN   = 32,
  parameter int WINDOW     = 256,
  parameter int ERR_LIMIT  = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [NB-1:0]         i_data,
  input  logic [$clog2(OS)-1:0] i_phase,
  input  logic                  i_clear,
  output logic                  o_locked,
  output logic [CNT_W-1:0]      o_bit_cnt,
  output logic [CNT_W-1:0]      o_err_cnt,
  output logic                  o_ber_zero
);

  localparam int PW  = $clog2(OS);
  localparam int FW  = $clog2(PRBS_ORDER + 1);
  localparam int MW  = $clog2(LOCK_LEN + 1);
  localparam int WBW = $clog2(WINDOW + 1);
  localparam int WEW = $clog2(ERR_LIMIT + 2);
  localparam int MSB = PRBS_ORDER - 1;
  localparam int TAP = (PRBS_ORDER == 7) ? 5 : (PRBS_ORDER == 15) ? 13 : 4;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t         state;
  logic [PW-1:0]  pc;
  logic [MSB:0]   s;
  logic [FW-1:0]  fill;
  logic [MW-1:0]  match;
  logic [WBW-1:0] win_bits;
  logic [WEW-1:0] win_err;

  logic             strobe, b, p, bit_inc, err_inc, win_end, lose, acquire, locked_nxt;
  logic [WEW-1:0]   win_err_nxt;
  logic [CNT_W-1:0] bit_nxt, err_nxt;
  logic             unused_data;

  assign unused_data = ^i_data[NB-2:0];

  always_comb begin
    strobe      = i_enable && (pc == i_phase);
    b           = ~i_data[NB-1];
    p           = s[MSB] ^ s[TAP];
    bit_inc     = strobe && (state == LOCKED);
    err_inc     = bit_inc && (b != p);
    win_err_nxt = (err_inc && (win_err != WEW'(ERR_LIMIT + 1))) ? win_err + 1'b1 : win_err;
    win_end     = bit_inc && (win_bits == WBW'(WINDOW - 1));
    lose        = win_end && (win_err_nxt > WEW'(ERR_LIMIT));
    acquire     = strobe && (state == VERIFY) && (s != '0) && (b == p) &&
                  (match == MW'(LOCK_LEN - 1));
    locked_nxt  = ((state == LOCKED) && !lose) || acquire;
    // clear takes precedence over a coincident count
    bit_nxt = i_clear ? '0 : (bit_inc && (o_bit_cnt != '1)) ? o_bit_cnt + 1'b1 : o_bit_cnt;
    err_nxt = i_clear ? '0 : (err_inc && (o_err_cnt != '1)) ? o_err_cnt + 1'b1 : o_err_cnt;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state      <= SEARCH;
      pc         <= '0;
      s          <= '0;
      fill       <= '0;
      match      <= '0;
      win_bits   <= '0;
      win_err    <= '0;
      o_locked   <= 1'b0;
      o_bit_cnt  <= '0;
      o_err_cnt  <= '0;
      o_ber_zero <= 1'b0;
    end else begin
      o_bit_cnt  <= bit_nxt;
      o_err_cnt  <= err_nxt;
      o_locked   <= locked_nxt;
      o_ber_zero <= locked_nxt && (err_nxt == '0) && (bit_nxt != '0);
      if (i_enable) pc <= (pc == PW'(OS - 1)) ? '0 : pc + 1'b1;
      if (strobe) begin
        case (state)
          SEARCH: begin
            s    <= {s[MSB-1:0], b};
            fill <= fill + 1'b1;
            if (fill == FW'(PRBS_ORDER - 1)) begin
              state <= VERIFY;
              match <= '0;
            end
          end
          VERIFY: begin
            if ((s == '0) || (b != p)) begin
              state <= SEARCH;
              fill  <= '0;
            end else begin
              s     <= {s[MSB-1:0], p};
              match <= match + 1'b1;
              if (acquire) begin
                state    <= LOCKED;
                win_bits <= '0;
                win_err  <= '0;
              end
            end
          end
          LOCKED: begin
            // local prediction only, so a received error never enters the LFSR
            s <= {s[MSB-1:0], p};
            if (win_end) begin
              win_bits <= '0;
              win_err  <= '0;
              if (lose) begin
                state <= SEARCH;
                fill  <= '0;
              end
            end else begin
              win_bits <= win_bits + 1'b1;
              win_err  <= win_err_nxt;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Bench for prbs_ber_checker: directed scenario table, hand-written timing sequences and
// randomized traffic compared every cycle against a bit-level reference model.
module tb_prbs_ber_checker;

  localparam int M_CLEAN = 0, M_FLIP = 1, M_INV = 2, M_ZERO = 3;

  logic              clock = 1'b0;
  logic              rst, en, clr;
  logic signed [7:0] data;
  logic [1:0]        phase;
  logic              lk, lk8, bz, bz8;
  logic [31:0]       bc, ec;
  logic [7:0]        bc8, ec8;
  int                total = 0, bad = 0;

  always #5 clock = ~clock;

  prbs_ber_checker #(.CNT_W(32)) dut (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_data(data), .i_phase(phase),
    .i_clear(clr), .o_locked(lk), .o_bit_cnt(bc), .o_err_cnt(ec), .o_ber_zero(bz));

  prbs_ber_checker #(.CNT_W(8)) dut8 (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_data(data), .i_phase(phase),
    .i_clear(clr), .o_locked(lk8), .o_bit_cnt(bc8), .o_err_cnt(ec8), .o_ber_zero(bz8));

  typedef struct {
    string  name;
    int     mode;
    int     nbits;
    logic   exp_locked;
    longint exp_bit;
    longint exp_err;
    logic   exp_bz;
    longint exp_bit8;
    longint exp_err8;
  } vec_t;

  vec_t tbl[6];

  // transmit PRBS9: x[m] = x[m-9] ^ x[m-5], first nine bits are seed 0x1AA MSB first
  logic gq[$] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0};

  // reference model state: mode 0 search, 1 verify, 2 locked; ms holds the last 9 reference bits
  int     m_pc = 0, m_mode = 0, m_match = 0, m_wb = 0, m_we = 0;
  longint m_bits = 0, m_errs = 0;
  logic   ms[$];

  task automatic check_val(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic gen_next();
    logic o;
    o = gq[0];
    gq.push_back(gq[0] ^ gq[4]);
    void'(gq.pop_front());
    return o;
  endfunction

  task automatic model_update();
    logic b, pred, allz;
    int   cnt, err;
    cnt = 0;
    err = 0;
    if (rst) begin
      m_pc = 0; m_mode = 0; m_match = 0; m_wb = 0; m_we = 0;
      m_bits = 0; m_errs = 0;
      ms.delete();
    end else begin
      if (en) begin
        if (m_pc == int'(phase)) begin
          b = ~data[7];
          if (m_mode == 0) begin
            ms.push_back(b);
            if (ms.size() == 9) begin m_mode = 1; m_match = 0; end
          end else begin
            pred = ms[0] ^ ms[4];
            allz = 1'b1;
            foreach (ms[i]) if (ms[i]) allz = 1'b0;
            if (m_mode == 1) begin
              if (allz || (b != pred)) begin
                m_mode = 0;
                ms.delete();
              end else begin
                ms.push_back(pred);
                void'(ms.pop_front());
                m_match++;
                if (m_match == 32) begin m_mode = 2; m_wb = 0; m_we = 0; end
              end
            end else begin
              ms.push_back(pred);
              void'(ms.pop_front());
              cnt = 1;
              err = (b != pred) ? 1 : 0;
              m_wb++;
              m_we += err;
              if (m_wb == 256) begin
                if (m_we > 8) begin m_mode = 0; ms.delete(); end
                m_wb = 0;
                m_we = 0;
              end
            end
          end
        end
        m_pc = (m_pc + 1) % 4;
      end
      if (clr) begin m_bits = 0; m_errs = 0; end
      else begin m_bits += cnt; m_errs += err; end
    end
  endtask

  task automatic compare_model();
    logic m_lk, m_bz;
    m_lk = (m_mode == 2);
    m_bz = m_lk && (m_errs == 0) && (m_bits != 0);
    check_val("model_locked", lk, m_lk);
    check_val("model_bit_cnt", bc, m_bits);
    check_val("model_err_cnt", ec, m_errs);
    check_val("model_ber_zero", bz, m_bz);
    check_val("model_locked8", lk8, m_lk);
    check_val("model_bit_cnt8", bc8, (m_bits > 255) ? 255 : m_bits);
    check_val("model_err_cnt8", ec8, (m_errs > 255) ? 255 : m_errs);
    check_val("model_ber_zero8", bz8, m_bz);
  endtask

  task automatic step(input logic signed [7:0] d);
    data = d;
    @(posedge clock);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic send_bit(input logic v);
    for (int j = 0; j < 4; j++) step(v ? 8'sd64 : -8'sd64);
  endtask

  task automatic send_row(input int mode, input int n);
    logic t;
    for (int i = 1; i <= n; i++) begin
      t = gen_next();
      case (mode)
        M_FLIP:  if (i % 100 == 0) t = ~t;
        M_INV:   t = ~t;
        M_ZERO:  t = 1'b0;
        default: ;
      endcase
      send_bit(t);
    end
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      send_row(tbl[r].mode, tbl[r].nbits);
      check_val({tbl[r].name, "_locked"}, lk, tbl[r].exp_locked);
      check_val({tbl[r].name, "_bit"}, bc, tbl[r].exp_bit);
      check_val({tbl[r].name, "_err"}, ec, tbl[r].exp_err);
      check_val({tbl[r].name, "_bz"}, bz, tbl[r].exp_bz);
      check_val({tbl[r].name, "_bit8"}, bc8, tbl[r].exp_bit8);
      check_val({tbl[r].name, "_err8"}, ec8, tbl[r].exp_err8);
    end
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, "_locked"}, lk, 0);
    check_val({name, "_bit"}, bc, 0);
    check_val({name, "_err"}, ec, 0);
    check_val({name, "_bz"}, bz, 0);
    check_val({name, "_bit8"}, bc8, 0);
    check_val({name, "_locked8"}, lk8, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(8'sd0);
    rst = 1'b0;
  endtask

  // 40 clean bits leave the checker unlocked; lock appears right after bit 41's strobe edge
  task automatic lock_seq();
    logic t;
    for (int k = 1; k <= 40; k++) send_bit(gen_next());
    check_val("prelock_locked", lk, 0);
    t = gen_next();
    for (int j = 0; j < 4; j++) begin
      step(t ? 8'sd64 : -8'sd64);
      if (j < int'(phase)) check_val("lock_early", lk, 0);
      else if (j == int'(phase)) check_val("lock_rise", lk, 1);
    end
    check_val("lock_bit_cnt", bc, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic t;
    int   dv;
    int   per_tbl[4];

    tbl[0] = '{"clean1000", M_CLEAN, 1000, 1'b1, 1000, 0, 1'b1, 255, 0};
    tbl[1] = '{"flip100", M_FLIP, 280, 1'b1, 1280, 2, 1'b0, 255, 2};
    tbl[2] = '{"inv_hold", M_INV, 1000, 1'b0, 1536, 258, 1'b0, 255, 255};
    tbl[3] = '{"sat300", M_CLEAN, 300, 1'b1, 300, 0, 1'b1, 255, 0};
    tbl[4] = '{"relock50", M_CLEAN, 50, 1'b1, 50, 0, 1'b1, 50, 0};
    tbl[5] = '{"all_zero", M_ZERO, 10000, 1'b0, 0, 0, 1'b0, 0, 0};
    per_tbl = '{0, 200, 20, 2};

    rst = 1'b1; en = 1'b1; clr = 1'b0; phase = 2'd2; data = '0;
    step(8'sd0);
    step(8'sd0);
    check_all_zero("reset");
    rst = 1'b0;

    lock_seq();
    apply_rows(0, 1);

    // inverted stream: 256 errors in one window, lock drops right after its last strobe
    for (int k = 1; k <= 255; k++) send_bit(~gen_next());
    check_val("inv_still_locked", lk, 1);
    check_val("inv_err_255", ec, 257);
    t = ~gen_next();
    for (int j = 0; j < 4; j++) begin
      step(t ? 8'sd64 : -8'sd64);
      if (j < int'(phase)) check_val("loss_early", lk, 1);
      else if (j == int'(phase)) check_val("loss_fall", lk, 0);
    end
    check_val("loss_err", ec, 258);
    apply_rows(2, 2);

    pulse_reset();
    check_all_zero("rst_unlocked");
    phase = 2'd0;
    lock_seq();
    apply_rows(3, 3);

    // clear on a strobe cycle wins over that bit's count
    t = gen_next();
    clr = 1'b1;
    step(t ? 8'sd64 : -8'sd64);
    clr = 1'b0;
    check_val("clr_bit", bc, 0);
    check_val("clr_err", ec, 0);
    check_val("clr_bit8", bc8, 0);
    check_val("clr_locked", lk, 1);
    check_val("clr_bz", bz, 0);
    for (int j = 1; j < 4; j++) step(t ? 8'sd64 : -8'sd64);
    check_val("clr_hold", bc, 0);
    t = gen_next();
    step(t ? 8'sd64 : -8'sd64);
    check_val("clr_resume", bc, 1);
    check_val("clr_resume8", bc8, 1);
    check_val("clr_resume_bz", bz, 1);
    for (int j = 1; j < 4; j++) step(t ? 8'sd64 : -8'sd64);

    en = 1'b0;
    for (int j = 0; j < 7; j++) step(8'($urandom));
    en = 1'b1;
    check_val("gap_bit", bc, 1);
    check_val("gap_err", ec, 0);
    check_val("gap_locked", lk, 1);
    send_row(M_CLEAN, 100);
    check_val("after_gap_bit", bc, 101);
    check_val("after_gap_err", ec, 0);
    check_val("after_gap_locked", lk, 1);

    pulse_reset();
    check_all_zero("rst_midlock");
    lock_seq();
    apply_rows(4, 4);

    pulse_reset();
    apply_rows(5, 5);

    // randomized traffic: random amplitudes, phases, error rates, enable gaps and clears
    pulse_reset();
    for (int seg = 0; seg < 4; seg++) begin
      phase = 2'($urandom_range(0, 3));
      for (int k = 0; k < 700; k++) begin
        t = gen_next();
        if (per_tbl[seg] != 0 && $urandom_range(1, per_tbl[seg]) == 1) t = ~t;
        for (int j = 0; j < 4; j++) begin
          if ($urandom_range(0, 9) == 0) begin
            en = 1'b0;
            step(8'($urandom));
            en = 1'b1;
          end
          clr = ($urandom_range(0, 499) == 0);
          dv = t ? int'($urandom_range(0, 127)) : -1 - int'($urandom_range(0, 127));
          step(8'(dv));
          clr = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
